// File: rtl/pheap_issue.sv
// pheap_issue: front-end issue controller for the pipelined heap root level.
// Ports: clk, rst_n, enq_i/deq_i/kv_in requests, ready_o, kv_out/kv_out_valid,
//        count_o/full_o/empty_o occupancy, op_o token to root, root_kv_i/root_done_i.
// Encodings: op field {FREE=0, LEQ=1, DEQ=2, ENQ_DEQ=3} in op_o[KV_W+1:KV_W],
//            kv = {key, val} with key in the upper bits, KV_EMPTY = 0,
//            root_done_i == 2 means WAIT (root busy).
module pheap_issue #(
  parameter int CAPACITY = 8,
  parameter int SPACING  = 2,
  parameter int KEY_W    = 16,
  parameter int VAL_W    = 16,
  localparam int KV_W    = KEY_W + VAL_W,
  localparam int OP_W    = KV_W + 2,
  localparam int CW      = $clog2(CAPACITY + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enq_i,
  input  logic            deq_i,
  input  logic [KV_W-1:0] kv_in,
  output logic            ready_o,
  output logic [KV_W-1:0] kv_out,
  output logic            kv_out_valid,
  output logic [CW-1:0]   count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [OP_W-1:0] op_o,
  input  logic [KV_W-1:0] root_kv_i,
  input  logic [1:0]      root_done_i
);

  localparam logic [1:0] OP_FREE    = 2'd0;
  localparam logic [1:0] OP_LEQ     = 2'd1;
  localparam logic [1:0] OP_DEQ     = 2'd2;
  localparam logic [1:0] OP_ENQ_DEQ = 2'd3;
  localparam logic [1:0] DN_WAIT    = 2'd2;

  localparam logic [KV_W-1:0] KV_EMPTY = '0;
  localparam logic [CW-1:0]   CAP_C    = CW'(CAPACITY);
  // COOL lasts SPACING-1 cycles: counter loads SPACING-2 and exits at zero
  localparam logic [1:0]      COOL_LD  = 2'(SPACING - 2);

  typedef enum logic {
    S_IDLE,
    S_COOL
  } state_t;

  state_t          r_state;
  logic [1:0]      r_cool;
  logic [OP_W-1:0] r_op;
  logic [KV_W-1:0] r_kv_out;
  logic            r_kv_vld;
  logic [CW-1:0]   r_count;

  logic w_wait;
  logic w_full;
  logic w_empty;
  logic w_both;
  logic w_enq1;
  logic w_deq1;
  logic w_legal;
  logic w_ready;
  logic w_acc;
  logic w_gt;
  logic w_byp;
  logic w_swap;
  logic w_issue;

  assign w_wait  = (root_done_i == DN_WAIT);
  assign w_full  = (r_count == CAP_C);
  assign w_empty = (r_count == '0);

  assign w_both  = enq_i & deq_i;
  assign w_enq1  = enq_i & ~deq_i;
  assign w_deq1  = deq_i & ~enq_i;
  assign w_legal = w_both | (w_enq1 & ~w_full) | (w_deq1 & ~w_empty);

  assign w_ready = (r_state == S_IDLE) & ~w_wait;
  assign w_acc   = w_ready & w_legal;

  // kv_in that outranks the root (or an empty heap) leaves straight away
  assign w_gt    = kv_in[KV_W-1 -: KEY_W] > root_kv_i[KV_W-1 -: KEY_W];
  assign w_byp   = w_both & (w_empty | w_gt);
  assign w_swap  = w_both & ~w_byp;
  assign w_issue = w_acc & ~w_byp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cool   <= '0;
      r_op     <= {OP_FREE, KV_EMPTY};
      r_kv_out <= KV_EMPTY;
      r_kv_vld <= 1'b0;
      r_count  <= '0;
    end else begin
      r_op     <= {OP_FREE, KV_EMPTY};
      r_kv_vld <= 1'b0;

      if (w_acc) begin
        unique case (1'b1)
          w_byp: begin
            r_kv_out <= kv_in;
            r_kv_vld <= 1'b1;
          end
          w_swap: begin
            r_op     <= {OP_ENQ_DEQ, kv_in};
            r_kv_out <= root_kv_i;
            r_kv_vld <= 1'b1;
          end
          w_enq1: begin
            r_op <= {OP_LEQ, kv_in};
          end
          default: begin
            r_op     <= {OP_DEQ, KV_EMPTY};
            r_kv_out <= root_kv_i;
            r_kv_vld <= 1'b1;
          end
        endcase
      end

      if (w_acc && w_enq1 && !w_full) begin
        r_count <= r_count + 1'b1;
      end else if (w_acc && w_deq1 && !w_empty) begin
        r_count <= r_count - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_issue && SPACING > 1) begin
            r_state <= S_COOL;
            r_cool  <= COOL_LD;
          end
        end
        S_COOL: begin
          if (r_cool == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cool <= r_cool - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o      = w_ready;
  assign op_o         = r_op;
  assign kv_out       = r_kv_out;
  assign kv_out_valid = r_kv_vld;
  assign count_o      = r_count;
  assign full_o       = w_full;
  assign empty_o      = w_empty;

endmodule

// File: tb/tb_pheap_issue.sv
// tb_pheap_issue: directed table, corner sequences and random run for pheap_issue.
// The bench plays the role of the heap: root_kv_i is the max of its own queue.
module tb_pheap_issue;

  localparam int CAP = 4;
  localparam int SP  = 2;
  localparam int KVW = 32;
  localparam int OPW = 34;
  localparam int CW  = 3;

  localparam logic [1:0] FREE    = 2'd0;
  localparam logic [1:0] LEQ     = 2'd1;
  localparam logic [1:0] DEQ     = 2'd2;
  localparam logic [1:0] ENQ_DEQ = 2'd3;
  localparam logic [1:0] DN_NOP  = 2'd0;
  localparam logic [1:0] DN_WAIT = 2'd2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enq_i;
  logic           deq_i;
  logic [KVW-1:0] kv_in;
  logic           ready_o;
  logic [KVW-1:0] kv_out;
  logic           kv_out_valid;
  logic [CW-1:0]  count_o;
  logic           full_o;
  logic           empty_o;
  logic [OPW-1:0] op_o;
  logic [KVW-1:0] root_kv_i;
  logic [1:0]     root_done_i;

  pheap_issue #(
    .CAPACITY(CAP),
    .SPACING (SP),
    .KEY_W   (16),
    .VAL_W   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enq_i       (enq_i),
    .deq_i       (deq_i),
    .kv_in       (kv_in),
    .ready_o     (ready_o),
    .kv_out      (kv_out),
    .kv_out_valid(kv_out_valid),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .op_o        (op_o),
    .root_kv_i   (root_kv_i),
    .root_done_i (root_done_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] hq[$];
  int          m_cyc;
  int          m_last;
  logic [31:0] m_kvout;

  // model expectations and DUT samples for the last tick
  logic        e_rdy, e_vld;
  logic [1:0]  e_op;
  logic [31:0] e_opkv, e_kvout;
  int          e_cnt;
  logic        s_rdy, s_vld, s_full, s_empty;
  logic [1:0]  s_op;
  logic [31:0] s_opkv, s_kvout;
  int          s_cnt;

  typedef struct {
    logic        e;
    logic        d;
    logic [15:0] k;
    logic        w;
    logic        rdy;
    logic [1:0]  op;
    logic [15:0] opk;
    logic        vld;
    logic [15:0] ok;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mk(input logic [15:0] k);
    return (k == 16'd0) ? 32'h0 : {k, k ^ 16'h5A5A};
  endfunction

  function automatic int hmax();
    int bi = -1;
    for (int i = 0; i < hq.size(); i++)
      if (bi < 0 || hq[i][31:16] > hq[bi][31:16]) bi = i;
    return bi;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    m_cyc   = 0;
    m_last  = -100;
    m_kvout = 32'h0;
  endtask

  task automatic do_reset();
    enq_i       = 1'b0;
    deq_i       = 1'b0;
    kv_in       = '0;
    root_kv_i   = '0;
    root_done_i = DN_NOP;
    rst_n       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // call just after a negedge; returns at the next negedge
  task automatic tick(input logic e, input logic d, input logic [15:0] k, input logic w);
    int  idx;
    logic full, empty, acc;
    idx         = hmax();
    enq_i       = e;
    deq_i       = d;
    kv_in       = mk(k);
    root_done_i = w ? DN_WAIT : DN_NOP;
    root_kv_i   = (idx < 0) ? 32'h0 : hq[idx];
    #1;
    s_rdy = ready_o;
    full  = (hq.size() == CAP);
    empty = (hq.size() == 0);
    e_rdy = (m_cyc - m_last >= SP) && !w;
    acc   = e_rdy && ((e && d) || (e && !d && !full) || (d && !e && !empty));
    e_op   = FREE;
    e_opkv = 32'h0;
    e_vld  = 1'b0;
    if (acc) begin
      if (e && d) begin
        e_vld = 1'b1;
        if (empty || k > hq[idx][31:16]) begin
          m_kvout = mk(k);
        end else begin
          m_kvout = hq[idx];
          hq.delete(idx);
          hq.push_back(mk(k));
          e_op   = ENQ_DEQ;
          e_opkv = mk(k);
        end
      end else if (e) begin
        hq.push_back(mk(k));
        e_op   = LEQ;
        e_opkv = mk(k);
      end else begin
        e_vld   = 1'b1;
        m_kvout = hq[idx];
        hq.delete(idx);
        e_op = DEQ;
      end
      if (e_op != FREE) m_last = m_cyc;
    end
    e_kvout = m_kvout;
    e_cnt   = hq.size();
    m_cyc++;
    @(posedge clk);
    #1;
    s_op    = op_o[33:32];
    s_opkv  = op_o[31:0];
    s_vld   = kv_out_valid;
    s_kvout = kv_out;
    s_cnt   = int'(count_o);
    s_full  = full_o;
    s_empty = empty_o;
    @(negedge clk);
  endtask

  task automatic add(input logic e, input logic d, input logic [15:0] k,
                     input logic rdy, input logic [1:0] op, input logic [15:0] opk,
                     input logic vld, input logic [15:0] ok, input int cnt);
    vec_t v;
    v.e = e; v.d = d; v.k = k; v.w = 1'b0;
    v.rdy = rdy; v.op = op; v.opk = opk;
    v.vld = vld; v.ok = ok; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    //  e  d  key rdy op      opk vld out cnt
    add(1, 0,  5, 1, LEQ,      5, 0,  0, 1);
    add(0, 0,  0, 0, FREE,     0, 0,  0, 1);
    add(1, 0,  9, 1, LEQ,      9, 0,  0, 2);
    add(1, 0,  3, 0, FREE,     0, 0,  0, 2);
    add(1, 0,  3, 1, LEQ,      3, 0,  0, 3);
    add(0, 0,  0, 0, FREE,     0, 0,  0, 3);
    add(0, 1,  0, 1, DEQ,      0, 1,  9, 2);
    add(0, 0,  0, 0, FREE,     0, 0,  9, 2);
    add(1, 0,  9, 1, LEQ,      9, 0,  9, 3);
    add(0, 0,  0, 0, FREE,     0, 0,  9, 3);
    add(1, 1, 12, 1, FREE,     0, 1, 12, 3);
    add(1, 1,  4, 1, ENQ_DEQ,  4, 1,  9, 3);
    add(1, 1,  4, 0, FREE,     0, 0,  9, 3);
    add(0, 1,  0, 1, DEQ,      0, 1,  5, 2);
    add(0, 0,  0, 0, FREE,     0, 0,  5, 2);
    add(0, 1,  0, 1, DEQ,      0, 1,  4, 1);
    add(0, 0,  0, 0, FREE,     0, 0,  4, 1);
    add(0, 1,  0, 1, DEQ,      0, 1,  3, 0);
    add(0, 1,  0, 0, FREE,     0, 0,  3, 0);
    add(0, 1,  0, 1, FREE,     0, 0,  3, 0);
    add(1, 1,  7, 1, FREE,     0, 1,  7, 0);
    add(1, 1,  8, 1, FREE,     0, 1,  8, 0);
    add(1, 1,  7, 1, FREE,     0, 1,  7, 0);
    add(1, 0,  1, 1, LEQ,      1, 0,  7, 1);
    add(0, 0,  0, 0, FREE,     0, 0,  7, 1);
    add(1, 0,  2, 1, LEQ,      2, 0,  7, 2);
    add(0, 0,  0, 0, FREE,     0, 0,  7, 2);
    add(1, 0,  3, 1, LEQ,      3, 0,  7, 3);
    add(0, 0,  0, 0, FREE,     0, 0,  7, 3);
    add(1, 0,  4, 1, LEQ,      4, 0,  7, 4);
    add(0, 0,  0, 0, FREE,     0, 0,  7, 4);
    add(1, 0,  6, 1, FREE,     0, 0,  7, 4);
    add(1, 1, 10, 1, FREE,     0, 1, 10, 4);
    add(1, 1,  2, 1, ENQ_DEQ,  2, 1,  4, 4);

    do_reset();
    // reset state, sampled mid-cycle after release
    #1;
    chk("rst.op",    op_o,         '0);
    chk("rst.kvout", kv_out,       '0);
    chk("rst.vld",   kv_out_valid, 1'b0);
    chk("rst.cnt",   count_o,      '0);
    chk("rst.empty", empty_o,      1'b1);
    chk("rst.full",  full_o,       1'b0);
    chk("rst.rdy",   ready_o,      1'b1);
    @(negedge clk);

    foreach (tbl[i]) begin
      tick(tbl[i].e, tbl[i].d, tbl[i].k, tbl[i].w);
      chk($sformatf("t%0d.rdy", i),   s_rdy,   tbl[i].rdy);
      chk($sformatf("t%0d.op", i),    s_op,    tbl[i].op);
      chk($sformatf("t%0d.opkv", i),  s_opkv,  mk(tbl[i].opk));
      chk($sformatf("t%0d.vld", i),   s_vld,   tbl[i].vld);
      chk($sformatf("t%0d.kvout", i), s_kvout, mk(tbl[i].ok));
      chk($sformatf("t%0d.cnt", i),   s_cnt,   tbl[i].cnt);
      chk($sformatf("t%0d.full", i),  s_full,  tbl[i].cnt == CAP);
      chk($sformatf("t%0d.empty", i), s_empty, tbl[i].cnt == 0);
    end

    // WAIT held 3 cycles with enq pending, then accepted once cleared
    do_reset();
    for (int j = 0; j < 3; j++) begin
      tick(1'b1, 1'b0, 16'd11, 1'b1);
      chk($sformatf("wait%0d.rdy", j), s_rdy, 1'b0);
      chk($sformatf("wait%0d.op", j),  s_op,  FREE);
      chk($sformatf("wait%0d.cnt", j), s_cnt, 0);
    end
    tick(1'b1, 1'b0, 16'd11, 1'b0);
    chk("wclr.rdy",  s_rdy,  1'b1);
    chk("wclr.op",   s_op,   LEQ);
    chk("wclr.opkv", s_opkv, mk(16'd11));
    chk("wclr.cnt",  s_cnt,  1);

    // asynchronous reset while cooling clears op and count at once
    enq_i = 1'b0;
    chk("cool.op", op_o[33:32], LEQ);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.op",    op_o,         '0);
    chk("arst.cnt",   count_o,      '0);
    chk("arst.empty", empty_o,      1'b1);
    chk("arst.vld",   kv_out_valid, 1'b0);
    chk("arst.rdy",   ready_o,      1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // randomized traffic against the queue model
    for (int j = 0; j < 400; j++) begin
      logic e, d, w;
      int   r;
      r = $urandom_range(0, 9);
      e = (r < 6);
      d = (r >= 3 && r < 9);
      w = ($urandom_range(0, 7) == 0);
      tick(e, d, 16'($urandom_range(1, 200)), w);
      chk($sformatf("r%0d.rdy", j),   s_rdy,   e_rdy);
      chk($sformatf("r%0d.op", j),    s_op,    e_op);
      chk($sformatf("r%0d.opkv", j),  s_opkv,  e_opkv);
      chk($sformatf("r%0d.vld", j),   s_vld,   e_vld);
      chk($sformatf("r%0d.kvout", j), s_kvout, e_kvout);
      chk($sformatf("r%0d.cnt", j),   s_cnt,   e_cnt);
      chk($sformatf("r%0d.full", j),  s_full,  e_cnt == CAP);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
